// File: rtl/gate_pkg.sv
// Shared types and helpers for the gate bank and its per-gate channels.
package gate_pkg;
  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } gate_state_t;

  // Counter width for a range of n distinct values, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gate_channel.sv
// One gate: open/close travel model with hold-open timer and safety reversal.
module gate_channel
  import gate_pkg::*;
#(
  parameter int MOVE_CYCLES = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic spot_filled,
  input  logic open_gate,
  input  logic near_gate,
  input  logic start_allow,
  output logic gate_open,
  output logic gate_moving,
  output logic gate_closed,
  output logic gate_reversed
);
  localparam int PW = cnt_w(MOVE_CYCLES + 1);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam logic [PW-1:0] POS_LAST = PW'(MOVE_CYCLES - 1);
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [HW-1:0] HOLD_TOP = HW'(HOLD_CYCLES - 1);

  gate_state_t   state;
  logic [PW-1:0] pos;
  logic [HW-1:0] hold;
  logic          rev;
  logic          req;

  assign req = spot_filled & open_gate;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLOSED;
      pos   <= '0;
      hold  <= '0;
      rev   <= 1'b0;
    end else begin
      rev <= 1'b0;
      case (state)
        CLOSED: if (req && start_allow) state <= OPENING;
        OPENING: begin
          pos <= pos + 1'b1;
          if (pos == POS_LAST) state <= OPEN;
        end
        OPEN: begin
          if (spot_filled || near_gate) hold <= '0;
          else if (hold == HOLD_TOP) begin
            state <= CLOSING;
            hold  <= '0;
          end else hold <= hold + 1'b1;
        end
        CLOSING: begin
          // Reversals keep pos so the gate only re-travels the distance it closed.
          if (near_gate) begin
            state <= OPENING;
            rev   <= 1'b1;
          end else if (req) state <= OPENING;
          else begin
            pos <= pos - 1'b1;
            if (pos == POS_ONE) state <= CLOSED;
          end
        end
        default: state <= CLOSED;
      endcase
    end
  end

  assign gate_open     = (state == OPEN);
  assign gate_moving   = (state == OPENING) || (state == CLOSING);
  assign gate_closed   = (state == CLOSED);
  assign gate_reversed = rev;
endmodule

// File: rtl/gate_bank.sv
// Bank of NUM_GATES independent gate channels.
// Optional GATE_BANK_INTERLOCK_EN: only one gate may leave CLOSED, lowest index wins.
module gate_bank
  import gate_pkg::*;
#(
  parameter int NUM_GATES   = 4,
  parameter int MOVE_CYCLES = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_GATES-1:0] spot_filled,
  input  logic [NUM_GATES-1:0] open_gate,
  input  logic [NUM_GATES-1:0] near_gate,
  output logic [NUM_GATES-1:0] gate_open,
  output logic [NUM_GATES-1:0] gate_moving,
  output logic [NUM_GATES-1:0] gate_closed,
  output logic [NUM_GATES-1:0] gate_reversed
);
  logic [NUM_GATES-1:0] start_allow;

`ifdef GATE_BANK_INTERLOCK_EN
  logic [NUM_GATES-1:0] start_req;
  logic [NUM_GATES-1:0] first_req;

  // Lowest set bit of the closed-gate requests; granted only when the whole bank is closed.
  assign start_req   = spot_filled & open_gate & gate_closed;
  assign first_req   = start_req & (~start_req + 1'b1);
  assign start_allow = {NUM_GATES{&gate_closed}} & first_req;
`else
  assign start_allow = '1;
`endif

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_ch
    gate_channel #(
      .MOVE_CYCLES(MOVE_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .spot_filled  (spot_filled[g]),
      .open_gate    (open_gate[g]),
      .near_gate    (near_gate[g]),
      .start_allow  (start_allow[g]),
      .gate_open    (gate_open[g]),
      .gate_moving  (gate_moving[g]),
      .gate_closed  (gate_closed[g]),
      .gate_reversed(gate_reversed[g])
    );
  end
endmodule

// File: tb/tb_gate_bank.sv
// Self-checking bench for gate_bank: directed scenarios plus randomized run against a behavioural model.
module tb_gate_bank;
  localparam int NG = 4, MV = 8, HD = 16;
  localparam int S_CLOSED = 0, S_OPENING = 1, S_OPEN = 2, S_CLOSING = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NG-1:0] spot = '0, opn = '0, near = '0;
  logic [NG-1:0] g_open, g_mov, g_cl, g_rev;
  int            tests = 0, fails = 0;

  int m_st[NG], m_pos[NG], m_hold[NG];
  bit m_rev[NG];

  gate_bank #(.NUM_GATES(NG), .MOVE_CYCLES(MV), .HOLD_CYCLES(HD)) dut (
    .clk(clk), .rst(rst), .spot_filled(spot), .open_gate(opn), .near_gate(near),
    .gate_open(g_open), .gate_moving(g_mov), .gate_closed(g_cl), .gate_reversed(g_rev)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; spot = '0; opn = '0; near = '0;
    tick;
    rst = 1'b0;
  endtask

  // Behavioural model: one call per clock edge with the inputs present at that edge.
  task automatic model_step(input bit r, input logic [NG-1:0] s, input logic [NG-1:0] o,
                            input logic [NG-1:0] n);
    bit allc = 1;
    int first = -1;
    bit allow;
    for (int i = 0; i < NG; i++) if (m_st[i] != S_CLOSED) allc = 0;
    for (int i = 0; i < NG; i++)
      if (first < 0 && m_st[i] == S_CLOSED && s[i] && o[i]) first = i;
    for (int i = 0; i < NG; i++) begin
`ifdef GATE_BANK_INTERLOCK_EN
      allow = allc && (first == i);
`else
      allow = 1;
`endif
      m_rev[i] = 0;
      if (r) begin
        m_st[i] = S_CLOSED; m_pos[i] = 0; m_hold[i] = 0;
      end else if (m_st[i] == S_CLOSED) begin
        if (s[i] && o[i] && allow) m_st[i] = S_OPENING;
      end else if (m_st[i] == S_OPENING) begin
        m_pos[i]++;
        if (m_pos[i] == MV) m_st[i] = S_OPEN;
      end else if (m_st[i] == S_OPEN) begin
        if (s[i] || n[i]) m_hold[i] = 0;
        else if (m_hold[i] == HD - 1) begin m_st[i] = S_CLOSING; m_hold[i] = 0; end
        else m_hold[i]++;
      end else begin
        if (n[i]) begin m_st[i] = S_OPENING; m_rev[i] = 1; end
        else if (s[i] && o[i]) m_st[i] = S_OPENING;
        else begin
          m_pos[i]--;
          if (m_pos[i] == 0) m_st[i] = S_CLOSED;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; spot = '0; opn = '0; near = '0;
    tick; tick;
    tests++;
    if ({g_cl, g_open, g_mov, g_rev} !== {4'b1111, 12'h000}) begin
      fails++;
      $display("FAIL reset_outputs: closed/open/moving/rev got %b %b %b %b want 1111 0000 0000 0000",
               g_cl, g_open, g_mov, g_rev);
    end
    rst = 1'b0;
    spot[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick;
      tests++;
      if (g_cl[0] !== 1'b1 || g_mov[0] !== 1'b0) begin
        fails++;
        $display("FAIL spot_no_request: cycle %0d closed=%b moving=%b want closed=1 moving=0",
                 k, g_cl[0], g_mov[0]);
      end
    end
    spot = '0;
  endtask

  task automatic test_open;
    do_reset;
    spot[1] = 1'b1; opn[1] = 1'b1;
    for (int k = 0; k < MV; k++) begin
      tick;
      tests++;
      if (g_mov[1] !== 1'b1 || g_open[1] !== 1'b0) begin
        fails++;
        $display("FAIL open_travel: after edge %0d moving=%b open=%b want moving=1 open=0",
                 k, g_mov[1], g_open[1]);
      end
    end
    tick;
    tests++;
    if (g_open[1] !== 1'b1 || g_mov[1] !== 1'b0) begin
      fails++;
      $display("FAIL open_done: after edge %0d open=%b moving=%b want open=1 moving=0",
               MV, g_open[1], g_mov[1]);
    end
  endtask

  task automatic test_hold_close;
    spot[1] = 1'b0; opn[1] = 1'b0;
    for (int k = 0; k < HD - 1; k++) begin
      tick;
      tests++;
      if (g_open[1] !== 1'b1) begin
        fails++;
        $display("FAIL hold_open: after edge %0d open=%b want 1", k, g_open[1]);
      end
    end
    for (int k = HD - 1; k < HD - 1 + MV; k++) begin
      tick;
      tests++;
      if (g_mov[1] !== 1'b1 || g_cl[1] !== 1'b0) begin
        fails++;
        $display("FAIL closing: after edge %0d moving=%b closed=%b want moving=1 closed=0",
                 k, g_mov[1], g_cl[1]);
      end
    end
    tick;
    tests++;
    if (g_cl[1] !== 1'b1 || g_mov[1] !== 1'b0) begin
      fails++;
      $display("FAIL close_done: closed=%b moving=%b want closed=1 moving=0", g_cl[1], g_mov[1]);
    end
  endtask

  task automatic test_reversal;
    int n = 0;
    do_reset;
    spot[2] = 1'b1; opn[2] = 1'b1;
    tick;
    spot[2] = 1'b0; opn[2] = 1'b0;
    while (g_open[2] !== 1'b1 && n < 30) begin tick; n++; end
    while (g_open[2] === 1'b1 && n < 60) begin tick; n++; end
    tests++;
    if (n >= 60 || g_mov[2] !== 1'b1) begin
      fails++;
      $display("FAIL rev_setup: gate 2 did not reach CLOSING (cycles=%0d moving=%b)", n, g_mov[2]);
    end
    tick; tick; tick;
    near[2] = 1'b1;
    tick;
    near[2] = 1'b0;
    tests++;
    if (g_rev !== 4'b0100 || g_mov[2] !== 1'b1) begin
      fails++;
      $display("FAIL rev_pulse: reversed=%b moving=%b want 0100 1", g_rev, g_mov[2]);
    end
    tick;
    tests++;
    if (g_rev !== 4'b0000 || g_mov[2] !== 1'b1) begin
      fails++;
      $display("FAIL rev_one_cycle: reversed=%b moving=%b want 0000 1", g_rev, g_mov[2]);
    end
    tick;
    tests++;
    if (g_open[2] !== 1'b0 || g_mov[2] !== 1'b1) begin
      fails++;
      $display("FAIL rev_partial: 2 edges after reversal open=%b want 0", g_open[2]);
    end
    tick;
    tests++;
    if (g_open[2] !== 1'b1) begin
      fails++;
      $display("FAIL rev_reopen: 3 edges after reversal open=%b want 1", g_open[2]);
    end
  endtask

  task automatic test_mid_reset;
    do_reset;
    spot[3] = 1'b1; opn[3] = 1'b1;
    for (int k = 0; k < 5; k++) tick;
    tests++;
    if (g_mov[3] !== 1'b1) begin
      fails++;
      $display("FAIL midrst_setup: moving=%b want 1", g_mov[3]);
    end
    rst = 1'b1;
    tick;
    tests++;
    if (g_cl !== 4'b1111 || g_open !== 4'b0000 || g_mov !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_abort: closed=%b open=%b moving=%b want 1111 0000 0000", g_cl, g_open, g_mov);
    end
    rst = 1'b0; spot[3] = 1'b0; opn[3] = 1'b0;
    tick;
    tests++;
    if (g_cl[3] !== 1'b1 || g_open[3] !== 1'b0) begin
      fails++;
      $display("FAIL midrst_stay: closed=%b open=%b want 1 0", g_cl[3], g_open[3]);
    end
    // A full-length reopen proves pos went back to 0.
    spot[3] = 1'b1; opn[3] = 1'b1;
    for (int k = 0; k < MV; k++) begin
      tick;
      tests++;
      if (g_open[3] !== 1'b0) begin
        fails++;
        $display("FAIL midrst_pos: after edge %0d open=%b want 0", k, g_open[3]);
      end
    end
    tick;
    tests++;
    if (g_open[3] !== 1'b1) begin
      fails++;
      $display("FAIL midrst_reopen: open=%b want 1", g_open[3]);
    end
  endtask

  task automatic test_interlock;
    int n = 0;
    bit held = 1;
    do_reset;
    spot = 4'b0101; opn = 4'b0101;
    tick;
    tests++;
`ifdef GATE_BANK_INTERLOCK_EN
    if (g_mov !== 4'b0001) begin
      fails++;
      $display("FAIL interlock_grant: moving=%b want 0001", g_mov);
    end
    spot[0] = 1'b0; opn[0] = 1'b0;
    while (g_cl[0] !== 1'b1 && n < 80) begin
      tick; n++;
      if (g_cl[2] !== 1'b1) held = 0;
    end
    tests++;
    if (n >= 80 || !held) begin
      fails++;
      $display("FAIL interlock_block: gate0 close cycles=%0d gate2 held closed=%0d want <80 1", n, held);
    end
    tick;
    tests++;
    if (g_mov[2] !== 1'b1) begin
      fails++;
      $display("FAIL interlock_release: gate2 moving=%b want 1", g_mov[2]);
    end
`else
    if (g_mov !== 4'b0101) begin
      fails++;
      $display("FAIL independent_start: moving=%b want 0101", g_mov);
    end
`endif
  endtask

  task automatic test_random;
    logic [NG-1:0] e_open, e_mov, e_cl, e_rev;
    int nprint = 0;
    do_reset;
    for (int i = 0; i < NG; i++) begin m_st[i] = S_CLOSED; m_pos[i] = 0; m_hold[i] = 0; m_rev[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199) == 0);
      for (int i = 0; i < NG; i++) begin
        spot[i] = ($urandom_range(9) < 4);
        opn[i]  = ($urandom_range(9) < 5);
        near[i] = ($urandom_range(99) < 8);
      end
      tick;
      model_step(rst, spot, opn, near);
      for (int i = 0; i < NG; i++) begin
        e_open[i] = (m_st[i] == S_OPEN);
        e_mov[i]  = (m_st[i] == S_OPENING) || (m_st[i] == S_CLOSING);
        e_cl[i]   = (m_st[i] == S_CLOSED);
        e_rev[i]  = m_rev[i];
      end
      tests++;
      if ({g_open, g_mov, g_cl, g_rev} !== {e_open, e_mov, e_cl, e_rev}) begin
        fails++;
        if (nprint < 10)
          $display("FAIL random_cycle %0d: open/mov/closed/rev got %b %b %b %b want %b %b %b %b",
                   c, g_open, g_mov, g_cl, g_rev, e_open, e_mov, e_cl, e_rev);
        nprint++;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_open;
    test_hold_close;
    test_reversal;
    test_mid_reset;
    test_interlock;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
